// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode seven-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always lit).
module seven_seg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned GUARD_CYCLES = 16,
    parameter int unsigned CNT_W        = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  x,
    output logic [3:0]  an,
    output logic        dp,
    output logic [1:0]  digit_sel,
    output logic        pending,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        StOff,
        StGuard,
        StShow
    } state_e;

    localparam bit              HasGuard  = (GUARD_CYCLES != 0);
    localparam logic [CNT_W-1:0] ShowLast  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GuardLast = HasGuard ? CNT_W'(GUARD_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
    localparam state_e           AfterShow = HasGuard ? StGuard : StShow;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         sel_q, sel_d;
    logic [15:0]        shown_q, shown_d;
    logic [15:0]        pbuf_q, pbuf_d;
    logic               pend_q, pend_d;
    logic               frame_q, frame_d;
    logic [3:0]         an_q, an_d;
    logic               dp_q, dp_d;
    logic [3:0]         x_q, x_d;
    logic               commit;
    logic               blank;
    logic               lit;

    // Scan sequencing: phase counter, digit index and frame-boundary commit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        commit  = 1'b0;
        frame_d = 1'b0;
        unique case (state_q)
            StOff: begin
                cnt_d = '0;
                sel_d = 2'd0;
                if (en) begin
                    commit  = 1'b1;
                    state_d = AfterShow;
                end
            end
            StGuard: begin
                if (!en) begin
                    state_d = StOff;
                    cnt_d   = '0;
                    sel_d   = 2'd0;
                end else if (cnt_q == GuardLast) begin
                    state_d = StShow;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StShow: begin
                if (!en) begin
                    state_d = StOff;
                    cnt_d   = '0;
                    sel_d   = 2'd0;
                end else if (cnt_q == ShowLast) begin
                    state_d = AfterShow;
                    cnt_d   = '0;
                    sel_d   = sel_q + 2'd1;
                    if (sel_q == 2'd3) begin
                        commit  = 1'b1;
                        frame_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StOff;
                cnt_d   = '0;
                sel_d   = 2'd0;
            end
        endcase
    end

    // A load coinciding with a commit bypasses the pending buffer.
    always_comb begin
        shown_d = shown_q;
        pbuf_d  = pbuf_q;
        pend_d  = pend_q;
        if (load) begin
            pbuf_d = value;
            pend_d = 1'b1;
        end
        if (commit) begin
            shown_d = load ? value : pbuf_q;
            pend_d  = 1'b0;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        blank = 1'b0;
        unique case (sel_d)
            2'd0: blank = 1'b0;
            2'd1: blank = (shown_d[15:4] == 12'h000);
            2'd2: blank = (shown_d[15:8] == 8'h00);
            2'd3: blank = (shown_d[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    // Outputs are derived from next-state so they change on the same edge as the state.
    always_comb begin
        lit  = (state_d == StShow) && !blank;
        an_d = 4'b1111;
        dp_d = 1'b1;
        x_d  = 4'h0;
        if (state_d != StOff) begin
            x_d = shown_d[{sel_d, 2'b00} +: 4];
        end
        if (lit) begin
            an_d[sel_d] = 1'b0;
            dp_d        = ~dp_mask[sel_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StOff;
            cnt_q   <= '0;
            sel_q   <= 2'd0;
            shown_q <= 16'h0000;
            pbuf_q  <= 16'h0000;
            pend_q  <= 1'b0;
            frame_q <= 1'b0;
            an_q    <= 4'b1111;
            dp_q    <= 1'b1;
            x_q     <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            shown_q <= shown_d;
            pbuf_q  <= pbuf_d;
            pend_q  <= pend_d;
            frame_q <= frame_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
            x_q     <= x_d;
        end
    end

    assign x          = x_q;
    assign an         = an_q;
    assign dp         = dp_q;
    assign digit_sel  = sel_q;
    assign pending    = pend_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: directed vector table, corner sequences and a
// frame-timeline reference model checked every cycle under random stimulus.
module tb_seven_seg_scan_ctrl;

    localparam int Refresh = 4;
    localparam int Guard   = 2;
    localparam int Slot    = Refresh + Guard;
    localparam int Frame   = 4 * Slot;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp_mask;
    logic [3:0]  x;
    logic [3:0]  an;
    logic        dp;
    logic [1:0]  digit_sel;
    logic        pending;
    logic        frame_done;

    seven_seg_scan_ctrl #(
        .REFRESH_DIV (Refresh),
        .GUARD_CYCLES(Guard),
        .CNT_W       (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .value     (value),
        .load      (load),
        .dp_mask   (dp_mask),
        .x         (x),
        .an        (an),
        .dp        (dp),
        .digit_sel (digit_sel),
        .pending   (pending),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: a running flag plus the elapsed cycle count since scanning began.
    bit          m_run   = 1'b0;
    int          m_t     = 0;
    logic [15:0] m_shown = 16'h0000;
    logic [15:0] m_pbuf  = 16'h0000;
    logic        m_pend  = 1'b0;
    logic        m_fd    = 1'b0;
    logic [3:0]  m_dpm   = 4'h0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit m_blank(input int d);
`ifdef LEADING_ZERO_BLANK_EN
        return (d > 0) && ((m_shown >> (4 * d)) == 16'h0000);
`else
        return (d < 0);
`endif
    endfunction

    task automatic step();
        bit          commit;
        int          p;
        int          d;
        bit          show;
        logic [3:0]  e_an;
        logic        e_dp;
        @(posedge clk);
        commit = 1'b0;
        m_fd   = 1'b0;
        m_dpm  = dp_mask;
        if (load) begin
            m_pbuf = value;
            m_pend = 1'b1;
        end
        if (!m_run) begin
            if (en) begin
                m_run  = 1'b1;
                m_t    = 0;
                commit = 1'b1;
            end
        end else if (!en) begin
            m_run = 1'b0;
        end else begin
            m_t++;
            if (m_t % Frame == 0) begin
                commit = 1'b1;
                m_fd   = 1'b1;
            end
        end
        if (commit) begin
            m_shown = m_pbuf;
            m_pend  = 1'b0;
        end
        #1;
        e_an = 4'b1111;
        e_dp = 1'b1;
        d    = 0;
        if (m_run) begin
            p    = m_t % Frame;
            d    = p / Slot;
            show = ((p % Slot) >= Guard) && !m_blank(d);
            if (show) begin
                e_an    = 4'b1111 & ~(4'b0001 << d);
                e_dp    = ~m_dpm[d];
            end
            chk("model_x", 16'(x), 16'((m_shown >> (4 * d)) & 16'h000F));
        end
        chk("model_an", 16'(an), 16'(e_an));
        chk("model_dp", 16'(dp), 16'(e_dp));
        chk("model_sel", 16'(digit_sel), 16'(d));
        chk("model_frame_done", 16'(frame_done), 16'(m_fd));
        chk("model_pending", 16'(pending), 16'(m_pend));
        chk("an_one_hot_low", 16'($countones(~an) <= 1), 16'(1));
    endtask

    task automatic wait_phase(input int ph, input string name);
        int k;
        k = 0;
        while ((m_t % Frame) != ph && k < 2 * Frame) begin
            step();
            k++;
        end
        if ((m_t % Frame) != ph) begin
            n_chk++;
            $display("FAIL %s: phase %0d, expected %0d", name, m_t % Frame, ph);
        end
    endtask

    typedef struct {
        logic        en;
        logic        ld;
        logic [15:0] val;
        logic [3:0]  dpm;
        int          n;
        logic [3:0]  an;
        logic        dp;
        logic [3:0]  x;
        logic [1:0]  sel;
        logic        fd;
        logic        pend;
    } vec_t;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [3:0] D1ZeroAn = 4'b1111;
`else
    localparam logic [3:0] D1ZeroAn = 4'b1101;
`endif

    vec_t tbl[12];

    initial begin
        int k;
        tbl[0]  = '{1, 0, 16'h0000, 4'h0, 1,  4'b1111, 1, 4'h0, 2'd0, 0, 0};
        tbl[1]  = '{1, 1, 16'h1234, 4'h0, 1,  4'b1111, 1, 4'h0, 2'd0, 0, 1};
        tbl[2]  = '{1, 0, 16'h0000, 4'h0, 1,  4'b1110, 1, 4'h0, 2'd0, 0, 1};
        tbl[3]  = '{1, 0, 16'h0000, 4'h0, 4,  4'b1111, 1, 4'h0, 2'd1, 0, 1};
        tbl[4]  = '{1, 0, 16'h0000, 4'h0, 2,  D1ZeroAn, 1, 4'h0, 2'd1, 0, 1};
        tbl[5]  = '{1, 0, 16'h0000, 4'h0, 16, 4'b1111, 1, 4'h4, 2'd0, 1, 0};
        tbl[6]  = '{1, 0, 16'h0000, 4'h0, 1,  4'b1111, 1, 4'h4, 2'd0, 0, 0};
        tbl[7]  = '{1, 0, 16'h0000, 4'h0, 1,  4'b1110, 1, 4'h4, 2'd0, 0, 0};
        tbl[8]  = '{1, 0, 16'h0000, 4'h0, 6,  4'b1101, 1, 4'h3, 2'd1, 0, 0};
        tbl[9]  = '{1, 0, 16'h0000, 4'h4, 6,  4'b1011, 0, 4'h2, 2'd2, 0, 0};
        tbl[10] = '{1, 0, 16'h0000, 4'h4, 6,  4'b0111, 1, 4'h1, 2'd3, 0, 0};
        tbl[11] = '{1, 0, 16'h0000, 4'h4, 4,  4'b1111, 1, 4'h4, 2'd0, 1, 0};

        rst_n   = 1'b0;
        en      = 1'b1;
        load    = 1'b0;
        value   = 16'h0000;
        dp_mask = 4'h0;
        #12;
        chk("rst_an", 16'(an), 16'hF);
        chk("rst_dp", 16'(dp), 16'h1);
        chk("rst_x", 16'(x), 16'h0);
        chk("rst_sel", 16'(digit_sel), 16'h0);
        chk("rst_frame_done", 16'(frame_done), 16'h0);
        chk("rst_pending", 16'(pending), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            en      = tbl[i].en;
            dp_mask = tbl[i].dpm;
            value   = tbl[i].val;
            for (int c = 0; c < tbl[i].n; c++) begin
                load = (c == 0) ? tbl[i].ld : 1'b0;
                step();
            end
            load = 1'b0;
            chk($sformatf("vec%0d_an", i), 16'(an), 16'(tbl[i].an));
            chk($sformatf("vec%0d_dp", i), 16'(dp), 16'(tbl[i].dp));
            chk($sformatf("vec%0d_x", i), 16'(x), 16'(tbl[i].x));
            chk($sformatf("vec%0d_sel", i), 16'(digit_sel), 16'(tbl[i].sel));
            chk($sformatf("vec%0d_fd", i), 16'(frame_done), 16'(tbl[i].fd));
            chk($sformatf("vec%0d_pend", i), 16'(pending), 16'(tbl[i].pend));
        end
        dp_mask = 4'h0;

        // Load landing exactly on the commit edge goes straight to the display.
        wait_phase(Frame - 1, "sync_bypass");
        load  = 1'b1;
        value = 16'hCAFE;
        step();
        load = 1'b0;
        chk("bypass_fd", 16'(frame_done), 16'h1);
        chk("bypass_pend", 16'(pending), 16'h0);
        chk("bypass_x", 16'(x), 16'hE);

        // Two loads mid-frame: last one wins at the next boundary.
        repeat (3) step();
        load  = 1'b1;
        value = 16'hAAAA;
        step();
        load = 1'b0;
        repeat (2) step();
        load  = 1'b1;
        value = 16'hBEEF;
        step();
        load = 1'b0;
        chk("dbl_pend_set", 16'(pending), 16'h1);
        chk("dbl_x_old", 16'(x), 16'((m_t % Frame) < Slot ? 4'hE : 4'hF) & 16'(x));
        k = 0;
        while (frame_done !== 1'b1 && k < 2 * Frame) begin
            step();
            k++;
        end
        chk("dbl_fd_seen", 16'(frame_done), 16'h1);
        chk("dbl_pend_clr", 16'(pending), 16'h0);
        chk("dbl_x_new", 16'(x), 16'hF);
        wait_phase(2 * Slot + Guard, "sync_d2_show");
        chk("d2_x", 16'(x), 16'hE);
        chk("d2_an", 16'(an), 16'hB);

        // Drop enable mid-SHOW of digit 2, then restart.
        step();
        en = 1'b0;
        step();
        chk("off_an", 16'(an), 16'hF);
        chk("off_sel", 16'(digit_sel), 16'h0);
        chk("off_dp", 16'(dp), 16'h1);
        step();
        chk("off_hold_an", 16'(an), 16'hF);
        en = 1'b1;
        step();
        chk("restart_sel", 16'(digit_sel), 16'h0);
        chk("restart_an", 16'(an), 16'hF);
        chk("restart_x", 16'(x), 16'hF);
        chk("restart_fd", 16'(frame_done), 16'h0);
        repeat (2) step();
        chk("restart_show_an", 16'(an), 16'hE);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            en      = ($urandom_range(0, 59) != 0);
            load    = ($urandom_range(0, 9) == 0);
            value   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            dp_mask = 4'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
